// File: rtl/nios_cpu_param_onchip_ram.sv
// Single-port on-chip RAM, Avalon-MM pipelined slave with byte enables,
// selectable read latency and a hardware clear sequencer.
module nios_cpu_param_onchip_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned OUTPUT_REG = 1,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    busy
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam state_t RST_STATE =
    (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_q1;
  logic                  r_vld_q1;

  logic w_en;
  logic w_idle;
  logic w_clr_we;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_en     = clken & ~reset_req;
  assign w_idle   = (r_state == S_IDLE);
  assign w_clr_we = w_en & ~w_idle & ~reset;
  assign w_wr_acc = w_en & w_idle & ~reset
                  & chipselect & write;
  assign w_rd_acc = w_en & w_idle & ~reset
                  & chipselect & read & ~write;

  assign waitrequest = ~w_idle;
  assign busy        = ~w_idle;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_en && clear)
          w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (w_en && r_clr_cnt == LAST)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= RST_STATE;
    else
      r_state <= w_state_nxt;
  end

  // Counter wraps to 0 naturally after the last word.
  always_ff @(posedge clk) begin
    if (reset)
      r_clr_cnt <= '0;
    else if (w_clr_we)
      r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= CLEAR_VALUE;
    end else if (w_wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (byteenable[i])
          r_mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_q1  <= '0;
      r_vld_q1 <= 1'b0;
    end else if (w_en) begin
      r_vld_q1 <= w_rd_acc;
      if (w_rd_acc)
        r_rd_q1 <= r_mem[address];
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r_rd_q2;
    logic                  r_vld_q2;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_rd_q2  <= '0;
        r_vld_q2 <= 1'b0;
      end else if (w_en) begin
        r_vld_q2 <= r_vld_q1;
        if (r_vld_q1)
          r_rd_q2 <= r_rd_q1;
      end
    end

    assign readdata      = r_rd_q2;
    assign readdatavalid = r_vld_q2;
  end else begin : g_noreg
    assign readdata      = r_rd_q1;
    assign readdatavalid = r_vld_q1;
  end

endmodule

// File: tb/tb_nios_cpu_param_onchip_ram.sv
// Directed bench: default RAM (latency 2, scrub on reset) and a small
// latency-1 RAM without reset scrub.
module tb_nios_cpu_param_onchip_ram;

  logic clk;
  logic reset;
  logic b_reset;
  logic clken;
  logic reset_req;

  logic        a_cs, a_rd, a_wr, a_clr;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [31:0] a_rdata;
  logic        a_rdv, a_wait, a_busy;

  logic        b_cs, b_rd, b_wr, b_clr;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic [31:0] b_rdata;
  logic        b_rdv, b_wait, b_busy;

  int n_chk;
  int n_err;

  nios_cpu_param_onchip_ram u_a (
    .clk           (clk),
    .reset         (reset),
    .clken         (clken),
    .reset_req     (reset_req),
    .chipselect    (a_cs),
    .read          (a_rd),
    .write         (a_wr),
    .address       (a_addr),
    .writedata     (a_wdata),
    .byteenable    (a_be),
    .clear         (a_clr),
    .readdata      (a_rdata),
    .readdatavalid (a_rdv),
    .waitrequest   (a_wait),
    .busy          (a_busy)
  );

  nios_cpu_param_onchip_ram #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (4),
    .OUTPUT_REG     (0),
    .CLEAR_ON_RESET (0)
  ) u_b (
    .clk           (clk),
    .reset         (b_reset),
    .clken         (clken),
    .reset_req     (reset_req),
    .chipselect    (b_cs),
    .read          (b_rd),
    .write         (b_wr),
    .address       (b_addr),
    .writedata     (b_wdata),
    .byteenable    (b_be),
    .clear         (b_clr),
    .readdata      (b_rdata),
    .readdatavalid (b_rdv),
    .waitrequest   (b_wait),
    .busy          (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [7:0] addr,
                         input logic [31:0] data,
                         input logic [3:0] be);
    a_cs = 1'b1; a_wr = 1'b1;
    a_addr = addr; a_wdata = data; a_be = be;
    step();
    a_cs = 1'b0; a_wr = 1'b0;
  endtask

  task automatic a_read(input logic [7:0] addr,
                        input logic [31:0] exp,
                        input string tag);
    a_cs = 1'b1; a_rd = 1'b1; a_addr = addr;
    step();
    a_cs = 1'b0; a_rd = 1'b0;
    chk({tag, "_v0"}, 32'(a_rdv), 0);
    step();
    chk({tag, "_v"}, 32'(a_rdv), 1);
    chk({tag, "_d"}, a_rdata, exp);
  endtask

  task automatic a_stall(input bit use_rr, input string tag);
    int n;
    a_cs = 1'b1; a_rd = 1'b1; a_addr = 8'd7;
    step();
    a_rd = 1'b0;
    if (use_rr) begin
      reset_req = 1'b1;
      a_wr = 1'b1; a_wdata = 32'h0; a_be = 4'hF;
    end else begin
      a_cs = 1'b0;
      clken = 1'b0;
    end
    n = 0;
    do begin
      step();
      n++;
      if (n == 3) begin
        clken = 1'b1; reset_req = 1'b0;
        a_wr = 1'b0; a_cs = 1'b0;
      end
    end while (!a_rdv && n < 10);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_d"}, a_rdata, 32'hDEADBEEF);
    step();
  endtask

  initial begin
    int n;
    logic seen;
    logic [7:0] v [5];
    logic [31:0] d [5];

    n_chk = 0; n_err = 0;
    reset = 1'b1; b_reset = 1'b1;
    clken = 1'b1; reset_req = 1'b0;
    a_cs = 0; a_rd = 0; a_wr = 0; a_clr = 0;
    a_addr = 0; a_wdata = 0; a_be = 0;
    b_cs = 0; b_rd = 0; b_wr = 0; b_clr = 0;
    b_addr = 0; b_wdata = 0; b_be = 0;

    step();
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rdv", 32'(a_rdv), 0);
    chk("rst_wait", 32'(a_wait), 1);
    chk("rst_busy", 32'(a_busy), 1);
    chk("b_rst_wait", 32'(b_wait), 0);
    chk("b_rst_busy", 32'(b_busy), 0);
    chk("b_rst_rdv", 32'(b_rdv), 0);
    chk("b_rst_rdata", b_rdata, 0);
    reset = 1'b0; b_reset = 1'b0;

    n = 0;
    while (a_wait && n < 400) begin step(); n++; end
    chk("scrub_len", n, 256);

    a_read(8'd0, 32'h0, "scrub0");
    a_read(8'd128, 32'h0, "scrub128");
    a_read(8'd255, 32'h0, "scrub255");

    a_write(8'd5, 32'hAABBCCDD, 4'b1111);
    a_write(8'd5, 32'h11223344, 4'b0101);
    a_read(8'd5, 32'hAA22CC44, "be");

    a_write(8'd1, 32'h1, 4'hF);
    a_write(8'd2, 32'h2, 4'hF);
    a_write(8'd3, 32'h3, 4'hF);
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        a_cs = 1'b1; a_rd = 1'b1; a_addr = 8'(c + 1);
      end else begin
        a_cs = 1'b0; a_rd = 1'b0;
      end
      step();
      v[c] = 8'(a_rdv);
      d[c] = a_rdata;
    end
    chk("pipe_v0", 32'(v[0]), 0);
    chk("pipe_v1", 32'(v[1]), 1);
    chk("pipe_v2", 32'(v[2]), 1);
    chk("pipe_v3", 32'(v[3]), 1);
    chk("pipe_v4", 32'(v[4]), 0);
    chk("pipe_d1", d[1], 32'h1);
    chk("pipe_d2", d[2], 32'h2);
    chk("pipe_d3", d[3], 32'h3);

    a_write(8'd7, 32'hDEADBEEF, 4'hF);
    a_stall(1'b0, "stall_ce");
    a_stall(1'b1, "stall_rr");
    a_read(8'd7, 32'hDEADBEEF, "rr_nowr");

    a_cs = 1'b1; a_rd = 1'b1; a_wr = 1'b1;
    a_addr = 8'd9; a_wdata = 32'h5A5A5A5A; a_be = 4'hF;
    step();
    a_cs = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
    seen = a_rdv;
    step(); seen |= a_rdv;
    step(); seen |= a_rdv;
    chk("coll_rdv", 32'(seen), 0);
    a_read(8'd9, 32'h5A5A5A5A, "coll_rd");

    a_cs = 1'b1; a_rd = 1'b1; a_addr = 8'd5;
    step();
    a_cs = 1'b0; a_rd = 1'b0; a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("infl_rdv", 32'(a_rdv), 1);
    chk("infl_d", a_rdata, 32'hAA22CC44);
    chk("clr_wait", 32'(a_wait), 1);
    n = 0;
    while (a_wait && n < 400) begin
      a_clr = (n == 99);
      step();
      n++;
    end
    a_clr = 1'b0;
    chk("clr_reclr_len", n, 256);
    a_read(8'd5, 32'h0, "clr5");

    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    n = 0;
    while (a_wait && n < 600) begin
      reset = (n == 149);
      step();
      n++;
    end
    reset = 1'b0;
    chk("clr_rst_len", n, 406);

    a_write(8'd3, 32'h33, 4'hF);
    a_read(8'd3, 32'h33, "pre_rst");
    a_cs = 1'b1; a_rd = 1'b1; a_addr = 8'd3;
    step();
    a_cs = 1'b0; a_rd = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstf_rdata", a_rdata, 0);
    chk("rstf_wait", 32'(a_wait), 1);
    seen = a_rdv;
    n = 0;
    while (a_wait && n < 400) begin
      step(); n++; seen |= a_rdv;
    end
    chk("rstf_rdv", 32'(seen), 0);
    chk("rstf_len", n, 256);

    b_cs = 1'b1; b_wr = 1'b1; b_addr = 4'd2;
    b_wdata = 32'h1111; b_be = 4'hF;
    step();
    b_wr = 1'b0; b_rd = 1'b1;
    step();
    chk("b_rd1_v", 32'(b_rdv), 1);
    chk("b_rd1_d", b_rdata, 32'h1111);
    b_rd = 1'b0; b_wr = 1'b1; b_wdata = 32'h2222;
    step();
    chk("b_wr_v", 32'(b_rdv), 0);
    chk("b_hold_d", b_rdata, 32'h1111);
    b_wr = 1'b0; b_rd = 1'b1;
    step();
    b_rd = 1'b0; b_cs = 1'b0;
    chk("b_rd2_v", 32'(b_rdv), 1);
    chk("b_rd2_d", b_rdata, 32'h2222);

    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    n = 0;
    while (b_wait && n < 100) begin step(); n++; end
    chk("b_clr_len", n, 16);
    b_cs = 1'b1; b_rd = 1'b1; b_addr = 4'd2;
    step();
    b_cs = 1'b0; b_rd = 1'b0;
    chk("b_clr_v", 32'(b_rdv), 1);
    chk("b_clr_d", b_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nios_cpu_param_onchip_ram.md
# nios_cpu_param_onchip_ram

Parametrised single-port on-chip RAM Avalon-MM slave for the Nios subsystem. It is the configurable successor to the fixed 256x8 scratch memories used by peripherals such as the VCTCXO tamer. It adds configurable width and depth, byte enables, selectable read latency with `readdatavalid`, and a hardware clear sequencer that holds off the bus with `waitrequest` while it scrubs the array. It sits on the Nios data master as a pipelined slave.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width in bits; multiple of 8, range 8–64.
- `ADDR_WIDTH`, 8: word address width; depth is `2**ADDR_WIDTH`.
- `OUTPUT_REG`, 1: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- `CLEAR_ON_RESET`, 1: 1 runs the clear sequence after every reset.
- `CLEAR_VALUE`, 0: `DATA_WIDTH`-bit value written to every word during a clear.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `clken`, in, 1: clock enable.
- `reset_req`, in, 1: reset-request gate. Effective enable is `en = clken & ~reset_req`.
- `chipselect`, in, 1: slave select.
- `read`, in, 1: read strobe, qualified by `chipselect`.
- `write`, in, 1: write strobe, qualified by `chipselect`.
- `address`, in, `ADDR_WIDTH`: word address.
- `writedata`, in, `DATA_WIDTH`: write data.
- `byteenable`, in, `DATA_WIDTH/8`: per-byte write enable. Ignored on reads.
- `clear`, in, 1: single-cycle pulse that starts a clear sequence.
- `readdata`, out, `DATA_WIDTH`: read data.
- `readdatavalid`, out, 1: one-cycle strobe marking valid `readdata`.
- `waitrequest`, out, 1: high while the slave stalls the master.
- `busy`, out, 1: high during a clear sequence.

## Operation
- The state machine has two states, IDLE and CLEAR. All transitions are gated by `en`, except reset.
- On `reset`:
  - the state goes to CLEAR if `CLEAR_ON_RESET`, otherwise to IDLE;
  - the clear counter goes to 0;
  - the read pipeline is flushed;
  - array contents are not reset.
- In CLEAR:
  - each `en` cycle writes `CLEAR_VALUE` to address `clr_cnt`, then increments `clr_cnt`;
  - after writing address `2**ADDR_WIDTH-1` the state goes to IDLE and `clr_cnt` wraps to 0.
- IDLE goes to CLEAR when `clear` is high and `en` is high. `clear` is ignored while in CLEAR; it neither restarts nor extends the sequence.
- `waitrequest` and `busy` both equal `(state==CLEAR)`. Bus accesses presented during CLEAR are not accepted; the master holds them.
- A write is accepted in IDLE when `en & chipselect & write`. Byte lane `i` is updated only if `byteenable[i]`.
- A read is accepted in IDLE when `en & chipselect & read & ~write`. If `read` and `write` are both high, the write is performed and the read is dropped, with no `readdatavalid`.
- Read-during-write to the same address returns the old data.
- When `en` is low:
  - the array is not written;
  - the read pipeline and `readdatavalid` hold their values, so no new strobe is issued;
  - the clear counter freezes.
- `readdata` holds its last value between reads. It is never driven to X after reset.

## Timing
- Reset values:
  - `readdata` = 0;
  - `readdatavalid` = 0;
  - `waitrequest` = `busy` = `CLEAR_ON_RESET`.
- Read latency counts `en` cycles from the accept edge:
  - `OUTPUT_REG`=0: data and `readdatavalid` appear after 1 cycle.
  - `OUTPUT_REG`=1: data and `readdatavalid` appear after 2 cycles.
- Back-to-back reads are accepted every cycle. This gives one `readdatavalid` per accepted read, in order, with full throughput.
- Write latency: data is visible to a read accepted on the next cycle.
- Clear duration is exactly `2**ADDR_WIDTH` `en`-high cycles. `waitrequest` falls on the edge after the last clear write.
- A `reset` asserted mid-clear restarts the sequence from address 0.
- A `reset` asserted with reads in flight discards them: no `readdatavalid` is issued for them.
- A `clear` pulse arriving while reads are in flight: the in-flight reads complete with their pre-clear data.

## Test plan
- Reset scrub (defaults): assert `reset` for 1 cycle with `en`=1.
  - Required: `waitrequest`=1 for exactly 256 cycles, then 0.
  - Required: reads of addresses 0, 128 and 255 return 0x00000000 with `readdatavalid` 2 cycles after accept.
- Byte enables: write 0xAABBCCDD to address 5 with `byteenable`=4'b1111, then write 0x11223344 with `byteenable`=4'b0101.
  - Required: a read of address 5 returns 0xAA22CC44.
- Pipelined reads with `OUTPUT_REG`=1: issue back-to-back reads of addresses 1, 2, 3 (preloaded 0x1, 0x2, 0x3).
  - Required: `readdatavalid` is high for 3 consecutive cycles starting 2 cycles after the first accept, with data 0x1, 0x2, 0x3.
- Stall: during a read in flight, drop `clken` for 3 cycles; separately, raise `reset_req` for 3 cycles.
  - Required: `readdatavalid` is delayed by exactly 3 cycles in each case and the data is unchanged.
  - Required: writes attempted while `reset_req`=1 leave the memory unmodified.
- Mid-clear events: pulse `clear` in IDLE and wait 100 cycles.
  - Pulse `clear` again: required, `waitrequest` still falls at cycle 256 after the first pulse.
  - Assert `reset` at cycle 150: required, `waitrequest` stays high for a further 256 cycles.
- Collisions:
  - Assert `read` and `write` together to address 9 with 0x5A5A5A5A: required, no `readdatavalid`, and a later read returns 0x5A5A5A5A.
  - With `OUTPUT_REG`=0, read and write the same address on adjacent cycles: required, the read returns the old value.
